pix_pair_packer: RTL and testbench
==================================

PIX_PAIR_PACKER -- requirements
Module: pix_pair_packer

Interface
REQ-001 Parameter FRAME_W, default 640: active pixels per line; SHALL be even.
REQ-002 Parameter FRAME_H, default 480: lines per frame.
REQ-003 Parameter ADDR_W, default 19: word address width; SHALL hold FRAME_W*FRAME_H/2-1.
REQ-004 Parameter FIFO_DEPTH, default 4: output word buffer entries; power of two, >=2.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 pix_in  in  18  one RGB666 pixel {R[17:12],G[11:6],B[5:0]}.
REQ-008 pix_valid  in  1  pix_in valid this cycle; no backpressure on input.
REQ-009 sof  in  1  start of frame; qualified by pix_valid; marks the first pixel of a frame.
REQ-010 two_pixel_vals  out  36  packed pair {second pixel[35:18], first pixel[17:0]}.
REQ-011 word_valid  out  1  FIFO head valid.
REQ-012 word_ready  in  1  consumer accepts head when word_valid&&word_ready.
REQ-013 word_addr  out  ADDR_W  linear word index of the head word within the frame.
REQ-014 overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
REQ-015 frame_done  out  1  one-cycle pulse when the last word of a frame enters the FIFO.

Function
REQ-016 States: IDLE (wait for sof), LOW (expect first pixel of pair), HIGH (expect second pixel).
REQ-017 IDLE: pix_valid&&sof -> capture pix_in as low half, wcnt<=0, go HIGH; pixels without sof ignored.
REQ-018 LOW: pix_valid -> capture low half, go HIGH.
REQ-019 HIGH: pix_valid -> form word {pix_in, low half}, push with address wcnt, wcnt<=wcnt+1, go LOW.
REQ-020 sof in LOW or HIGH: discard any pending low half, no push; sof pixel becomes new low half, wcnt<=0, go HIGH.
REQ-021 Push of word with wcnt = FRAME_W*FRAME_H/2-1: frame_done=1 next cycle, go IDLE; wcnt never wraps within a frame.
REQ-022 Latency: word pushed into an empty FIFO on edge N SHALL appear with word_valid=1 after edge N (visible in cycle N+1).
REQ-023 word_valid = FIFO not empty; two_pixel_vals/word_addr = head entry, registered storage, stable while word_valid&&!word_ready.
REQ-024 Pop on word_valid&&word_ready; FIFO order strictly preserved.
REQ-025 Push while full and no pop: word dropped, wcnt still increments, overflow<=1.
REQ-026 Push while full with simultaneous pop: both performed, no drop, occupancy unchanged.
REQ-027 Push and pop on non-full, non-empty FIFO: occupancy unchanged.
REQ-028 Read/write pointers wrap modulo FIFO_DEPTH; full/empty via occupancy count 0..FIFO_DEPTH.
REQ-029 overflow cleared only by reset; sof does not clear it.
REQ-030 FIFO contents not flushed by sof; words from previous frame drain normally.
REQ-031 frame_done SHALL not assert if the final word was dropped by overflow.

Reset
REQ-032 reset low asynchronously forces: state IDLE, wcnt=0, FIFO empty, word_valid=0, two_pixel_vals=0, word_addr=0, overflow=0, frame_done=0.
REQ-033 reset asserted mid-frame discards pending half pair and all FIFO entries; after release, block waits for sof.
REQ-034 reset deassertion synchronised by the top level; block samples normally from first edge after release.

Verification
REQ-035 Pair packing: word_ready=1, sof+pix 0x00001, then pix 0x3FFFF -> next cycle word_valid=1, two_pixel_vals=0xFFFFC0001, word_addr=0.
REQ-036 Backpressure: word_ready=0, push 5 words (FIFO_DEPTH=4) -> word_valid=1, overflow=1, head addr=0; raise word_ready -> addrs 0,1,2,3 drain, 4 absent.
REQ-037 Full with simultaneous pop: FIFO full, word_ready=1 on the cycle a 5th word completes -> overflow stays 0, addrs 0..4 all delivered in order.
REQ-038 Mid-pair sof: sof+A, B, C, sof+D, E -> words {B,A} addr 0 then {E,D} addr 0; C never output.
REQ-039 Frame end: FRAME_W=4, FRAME_H=2, 8 continuous pixels -> words addr 0..3, frame_done pulses once after addr 3 push; following non-sof pixels produce no words.
REQ-040 Async reset: assert reset between edges with 3 words queued -> word_valid=0, overflow=0 immediately, before next clk edge.

Source files
------------

// File: rtl/pix_pair_packer_if.sv
// Pixel-pair packer bus bundle.
// Groups the pixel input stream and the packed-word output stream so the
// packer and its producer/consumer can be wired with a single connection.
//   pix_in[17:0]          RGB666 pixel {R,G,B}
//   pix_valid             pix_in valid this cycle (no backpressure)
//   sof                   start of frame, qualified by pix_valid
//   two_pixel_vals[35:0]  head word {second pixel, first pixel}
//   word_valid            head word valid
//   word_ready            consumer accepts the head word
//   word_addr[ADDR_W-1:0] linear word index of the head word
//   overflow              sticky: a completed word was dropped
//   frame_done            one-cycle pulse when a frame's last word is stored
// The master modport is the side that feeds pixels and consumes words;
// the slave modport is the packer itself.
interface pix_pair_packer_if #(
   parameter int ADDR_W = 19
);
   logic [17:0]       pix_in;
   logic              pix_valid;
   logic              sof;
   logic [35:0]       two_pixel_vals;
   logic              word_valid;
   logic              word_ready;
   logic [ADDR_W-1:0] word_addr;
   logic              overflow;
   logic              frame_done;

   modport master (
      output pix_in, pix_valid, sof, word_ready,
      input  two_pixel_vals, word_valid, word_addr, overflow, frame_done
   );

   modport slave (
      input  pix_in, pix_valid, sof, word_ready,
      output two_pixel_vals, word_valid, word_addr, overflow, frame_done
   );
endinterface

// File: rtl/pix_pair_packer.sv
// Pixel-pair packer.
// Packs consecutive RGB666 pixels of a frame into 36-bit words
// {second pixel, first pixel}, tags each word with its linear index within
// the frame and queues it in a small FIFO for a ready/valid consumer.
// Ports:
//   clk    single clock, all state on the rising edge
//   reset  asynchronous, active-low reset
//   bus    pix_pair_packer_if slave modport (pixel input, word output)
module pix_pair_packer #(
   parameter int FRAME_W    = 640,
   parameter int FRAME_H    = 480,
   parameter int ADDR_W     = 19,
   parameter int FIFO_DEPTH = 4
) (
   input logic              clk,
   input logic              reset,
   pix_pair_packer_if.slave bus
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_W * FRAME_H / 2 - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   state_t            state_q;
   logic [17:0]       lowPix_q;
   logic [ADDR_W-1:0] wordCnt_q;
   logic              frameDone_q;
   logic              overflow_q;

   logic [35:0]       dataMem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] addrMem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic pushReq, isLast, fifoFull, fifoEmpty, pop, doWrite, drop;

   // A word completes only on a non-sof pixel while holding a low half;
   // a sof pixel always restarts pairing and never pushes.
   // A completed word is stored if there is room, or if the head is being
   // popped in the same cycle; otherwise it is dropped.
   always_comb begin
      pushReq   = bus.pix_valid && !bus.sof && (state_q == HIGH);
      isLast    = (wordCnt_q == LAST_WORD);
      fifoFull  = (count_q == FULL_CNT);
      fifoEmpty = (count_q == '0);
      pop       = !fifoEmpty && bus.word_ready;
      doWrite   = pushReq && (!fifoFull || pop);
      drop      = pushReq && fifoFull && !pop;
      wrPtr_d   = doWrite ? wrPtr_q + PTR_W'(1) : wrPtr_q;
      rdPtr_d   = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
      count_d   = count_q;
      if (doWrite && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !doWrite) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pairing state machine. The word counter stops at the last word of the
   // frame and the machine parks in IDLE until the next sof. frame_done is
   // only raised when that last word actually made it into the FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         lowPix_q    <= '0;
         wordCnt_q   <= '0;
         frameDone_q <= 1'b0;
      end else begin
         frameDone_q <= 1'b0;
         if (bus.pix_valid) begin
            if (bus.sof) begin
               lowPix_q  <= bus.pix_in;
               wordCnt_q <= '0;
               state_q   <= HIGH;
            end else begin
               case (state_q)
                  LOW: begin
                     lowPix_q <= bus.pix_in;
                     state_q  <= HIGH;
                  end
                  HIGH: begin
                     frameDone_q <= isLast && doWrite;
                     if (isLast) begin
                        state_q <= IDLE;
                     end else begin
                        wordCnt_q <= wordCnt_q + ADDR_W'(1);
                        state_q   <= LOW;
                     end
                  end
                  default: begin
                     state_q <= IDLE;
                  end
               endcase
            end
         end
      end
   end

   // Output word FIFO. Storage is cleared on reset so the head outputs read
   // zero until the first word arrives; pointers wrap naturally because the
   // depth is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            dataMem_q[i] <= '0;
            addrMem_q[i] <= '0;
         end
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (doWrite) begin
            dataMem_q[wrPtr_q] <= {bus.pix_in, lowPix_q};
            addrMem_q[wrPtr_q] <= wordCnt_q;
         end
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         count_q    <= count_d;
         overflow_q <= overflow_q | drop;
      end
   end

   assign bus.word_valid     = !fifoEmpty;
   assign bus.two_pixel_vals = dataMem_q[rdPtr_q];
   assign bus.word_addr      = addrMem_q[rdPtr_q];
   assign bus.overflow       = overflow_q;
   assign bus.frame_done     = frameDone_q;

endmodule

// File: tb/tb_pix_pair_packer.sv
// Testbench for pix_pair_packer.
// Two packers share clock and reset: dutA uses the default 640x480 frame,
// dutB a 4x2 frame so the end-of-frame behaviour is reachable quickly.
// A behavioural model runs alongside each DUT and queues the words it
// expects; monitors pop and compare on every accepted word.
module tb_pix_pair_packer;

   localparam int ADDR_W = 19;
   localparam int DEPTH  = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   pix_pair_packer_if #(.ADDR_W(ADDR_W)) ifA ();
   pix_pair_packer_if #(.ADDR_W(ADDR_W)) ifB ();

   pix_pair_packer #(.FRAME_W(640), .FRAME_H(480), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (ifA)
   );

   pix_pair_packer #(.FRAME_W(4), .FRAME_H(2), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (ifB)
   );

   logic        drvValid [2];
   logic        drvSof   [2];
   logic        drvReady [2];
   logic [17:0] drvPix   [2];

   assign ifA.pix_valid  = drvValid[0];
   assign ifA.sof        = drvSof[0];
   assign ifA.pix_in     = drvPix[0];
   assign ifA.word_ready = drvReady[0];
   assign ifB.pix_valid  = drvValid[1];
   assign ifB.sof        = drvSof[1];
   assign ifB.pix_in     = drvPix[1];
   assign ifB.word_ready = drvReady[1];

   int testsRun    = 0;
   int testsFailed = 0;

   // Expected words as {addr, data}, one queue per DUT.
   logic [ADDR_W+35:0] expQA [$];
   logic [ADDR_W+35:0] expQB [$];
   logic [ADDR_W+35:0] eA, eB;

   // Behavioural model state: 0 = waiting for sof, 1 = need first pixel,
   // 2 = need second pixel.
   int          mState   [2];
   logic [17:0] mLow     [2];
   int          mWcnt    [2];
   int          mCnt     [2];
   logic        mOvf     [2];
   logic        mFd      [2];
   int          lastWord [2];
   int          fdCountB;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mState[i] = 0;
         mLow[i]   = '0;
         mWcnt[i]  = 0;
         mCnt[i]   = 0;
         mOvf[i]   = 1'b0;
         mFd[i]    = 1'b0;
      end
      expQA.delete();
      expQB.delete();
   endtask

   // Advance the models by one clock using the inputs currently driven,
   // clock the DUTs, then compare the per-cycle status outputs.
   task automatic tick();
      for (int i = 0; i < 2; i++) begin
         bit popNow, pushNow, lastNow;
         logic [ADDR_W+35:0] w;
         popNow  = (mCnt[i] > 0) && drvReady[i];
         pushNow = 1'b0;
         lastNow = 1'b0;
         w       = '0;
         if (drvValid[i]) begin
            if (drvSof[i]) begin
               mLow[i]   = drvPix[i];
               mWcnt[i]  = 0;
               mState[i] = 2;
            end else if (mState[i] == 1) begin
               mLow[i]   = drvPix[i];
               mState[i] = 2;
            end else if (mState[i] == 2) begin
               pushNow = 1'b1;
               w       = {ADDR_W'(mWcnt[i]), drvPix[i], mLow[i]};
               lastNow = (mWcnt[i] == lastWord[i]);
               if (lastNow) begin
                  mState[i] = 0;
               end else begin
                  mWcnt[i]++;
                  mState[i] = 1;
               end
            end
         end
         mFd[i] = 1'b0;
         if (pushNow) begin
            if (mCnt[i] < DEPTH || popNow) begin
               if (i == 0) expQA.push_back(w);
               else        expQB.push_back(w);
               mCnt[i]++;
               mFd[i] = lastNow;
            end else begin
               mOvf[i] = 1'b1;
            end
         end
         if (popNow) mCnt[i]--;
      end
      @(posedge clk);
      #1;
      if (ifB.frame_done) fdCountB++;
      checkOutput("A word_valid", ifA.word_valid, mCnt[0] > 0);
      checkOutput("A overflow",   ifA.overflow,   mOvf[0]);
      checkOutput("A frame_done", ifA.frame_done, mFd[0]);
      checkOutput("B word_valid", ifB.word_valid, mCnt[1] > 0);
      checkOutput("B overflow",   ifB.overflow,   mOvf[1]);
      checkOutput("B frame_done", ifB.frame_done, mFd[1]);
   endtask

   // Drive one cycle of pixel input into the selected DUT; the other DUT
   // sees no pixel that cycle.
   task automatic applyStimulus(input int sel, input logic valid, input logic sof, input logic [17:0] pix);
      for (int i = 0; i < 2; i++) begin
         drvValid[i] = (i == sel) ? valid : 1'b0;
         drvSof[i]   = (i == sel) ? sof : 1'b0;
         drvPix[i]   = (i == sel) ? pix : 18'h0;
      end
      tick();
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(0, 1'b0, 1'b0, 18'h0);
   endtask

   // Assert reset between clock edges and confirm it takes effect at once.
   task automatic applyReset();
      reset = 1'b0;
      #1;
      checkOutput("rst A word_valid", ifA.word_valid, 0);
      checkOutput("rst A overflow",   ifA.overflow, 0);
      checkOutput("rst A data",       ifA.two_pixel_vals, 0);
      checkOutput("rst A addr",       ifA.word_addr, 0);
      checkOutput("rst A frame_done", ifA.frame_done, 0);
      checkOutput("rst B word_valid", ifB.word_valid, 0);
      checkOutput("rst B overflow",   ifB.overflow, 0);
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Word monitors: every accepted head word must match the model's next word.
   always @(negedge clk) begin
      if (reset) begin
         if (ifA.word_valid && ifA.word_ready) begin
            if (expQA.size() == 0) begin
               checkOutput("A spurious word", 1, 0);
            end else begin
               eA = expQA.pop_front();
               checkOutput("A word data", ifA.two_pixel_vals, eA[35:0]);
               checkOutput("A word addr", ifA.word_addr, eA[ADDR_W+35:36]);
            end
         end
         if (ifB.word_valid && ifB.word_ready) begin
            if (expQB.size() == 0) begin
               checkOutput("B spurious word", 1, 0);
            end else begin
               eB = expQB.pop_front();
               checkOutput("B word data", ifB.two_pixel_vals, eB[35:0]);
               checkOutput("B word addr", ifB.word_addr, eB[ADDR_W+35:36]);
            end
         end
      end
   end

   initial begin
      logic [17:0] p;
      lastWord[0] = 640 * 480 / 2 - 1;
      lastWord[1] = 4 * 2 / 2 - 1;
      fdCountB    = 0;
      for (int i = 0; i < 2; i++) begin
         drvValid[i] = 1'b0;
         drvSof[i]   = 1'b0;
         drvReady[i] = 1'b1;
         drvPix[i]   = '0;
      end
      modelReset();
      applyReset();

      // Basic pair packing.
      applyStimulus(0, 1'b1, 1'b1, 18'h00001);
      applyStimulus(0, 1'b1, 1'b0, 18'h3FFFF);
      checkOutput("pack word_valid", ifA.word_valid, 1);
      checkOutput("pack data",       ifA.two_pixel_vals, 36'hFFFFC0001);
      checkOutput("pack addr",       ifA.word_addr, 0);
      idleCycles(2);

      // Backpressure: five words into a four-entry FIFO.
      drvReady[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         p = 18'($urandom);
         applyStimulus(0, 1'b1, k == 0, p);
      end
      applyStimulus(0, 1'b0, 1'b0, 18'h0);
      checkOutput("bp overflow",  ifA.overflow, 1);
      checkOutput("bp head addr", ifA.word_addr, 0);
      drvReady[0] = 1'b1;
      idleCycles(6);
      checkOutput("bp drained", expQA.size(), 0);

      // Asynchronous reset with three words queued and overflow set.
      drvReady[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         p = 18'($urandom);
         applyStimulus(0, 1'b1, k == 0, p);
      end
      applyStimulus(0, 1'b0, 1'b0, 18'h0);
      checkOutput("pre-rst queued", ifA.word_valid, 1);
      applyReset();
      idleCycles(1);

      // Full FIFO with a pop in the same cycle the fifth word completes.
      drvReady[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         p = 18'($urandom);
         if (k == 9) drvReady[0] = 1'b1;
         applyStimulus(0, 1'b1, k == 0, p);
      end
      idleCycles(6);
      checkOutput("full+pop overflow", ifA.overflow, 0);
      checkOutput("full+pop drained",  expQA.size(), 0);

      // sof in the middle of a pair restarts pairing and addressing.
      applyStimulus(0, 1'b1, 1'b1, 18'h0000A);
      applyStimulus(0, 1'b1, 1'b0, 18'h0000B);
      applyStimulus(0, 1'b1, 1'b0, 18'h0000C);
      applyStimulus(0, 1'b1, 1'b1, 18'h0000D);
      applyStimulus(0, 1'b1, 1'b0, 18'h0000E);
      checkOutput("midsof data", ifA.two_pixel_vals, {18'h0000E, 18'h0000D});
      checkOutput("midsof addr", ifA.word_addr, 0);
      idleCycles(3);
      checkOutput("midsof drained", expQA.size(), 0);

      // End of frame on the 4x2 packer, then stray pixels without sof.
      fdCountB = 0;
      for (int k = 0; k < 12; k++) begin
         p = 18'($urandom);
         applyStimulus(1, 1'b1, k == 0, p);
      end
      for (int k = 0; k < 4; k++) applyStimulus(1, 1'b0, 1'b0, 18'h0);
      checkOutput("B frame_done pulses", fdCountB, 1);
      checkOutput("B drained", expQB.size(), 0);

      // Random traffic with random backpressure and occasional sof.
      for (int k = 0; k < 300; k++) begin
         p = 18'($urandom);
         drvReady[0] = 1'($urandom_range(0, 1));
         applyStimulus(0, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 19) == 0, p);
      end
      drvReady[0] = 1'b1;
      idleCycles(8);
      checkOutput("rand drained", expQA.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
